// File: rtl/sub_seq.sv
// Nibble-serial subtractor: d = a - b - bin, four bits per clock through one
// 4-bit adder slice (a + ~b + carry), with borrow/overflow/zero/negative flags.
module sub_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             op_start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf,
  output logic             zero,
  output logic             neg,
  output logic             busy,
  output logic             done
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             c_reg;
  logic [IW-1:0]    idx_reg;

  logic             accept;
  logic             last;
  logic [3:0]       a_nib;
  logic [3:0]       b_inv;
  logic [4:0]       sum;
  logic [WIDTH-1:0] d_merged;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; a start in DONE chains straight into the next run
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    state_next = op_start ? RUN : IDLE;
      RUN:     state_next = last ? DONE : RUN;
      DONE:    state_next = op_start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy   = (state_reg == RUN);
    done   = (state_reg == DONE);
    accept = op_start && (state_reg != RUN);
    last   = (state_reg == RUN) && (idx_reg == IW'(NIB - 1));
  end

  // One nibble slice; d_merged is d with the current nibble already written,
  // so the flags can be taken from the final value on the last RUN edge.
  always_comb begin
    a_nib    = a_reg[4*idx_reg +: 4];
    b_inv    = ~b_reg[4*idx_reg +: 4];
    sum      = {1'b0, a_nib} + {1'b0, b_inv} + {4'b0000, c_reg};
    d_merged = d;
    d_merged[4*idx_reg +: 4] = sum[3:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      c_reg   <= 1'b0;
      idx_reg <= '0;
      d       <= '0;
      bout    <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
      neg     <= 1'b0;
    end else if (accept) begin
      a_reg   <= a;
      b_reg   <= b;
      c_reg   <= ~bin;
      idx_reg <= '0;
      d       <= '0;
      bout    <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
      neg     <= 1'b0;
    end else if (state_reg == RUN) begin
      d       <= d_merged;
      c_reg   <= sum[4];
      idx_reg <= idx_reg + 1'b1;
      if (last) begin
        bout <= ~sum[4];
        ovf  <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                (d_merged[WIDTH-1] != a_reg[WIDTH-1]);
        zero <= (d_merged == '0);
        neg  <= d_merged[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_sub_seq.sv
// Randomized and directed bench for sub_seq, checked against a wide-integer
// arithmetic model of a - b - bin.
module tb_sub_seq;

  localparam int WIDTH = 32;
  localparam int NIB   = WIDTH / 4;
  localparam int RW    = WIDTH + 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             op_start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             bin = 1'b0;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             ovf;
  logic             zero;
  logic             neg;
  logic             busy;
  logic             done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  sub_seq #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .op_start (op_start),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .d        (d),
    .bout     (bout),
    .ovf      (ovf),
    .zero     (zero),
    .neg      (neg),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Packed result {d, bout, ovf, zero, neg}
  function automatic logic [RW-1:0] observed();
    return {d, bout, ovf, zero, neg};
  endfunction

  // Reference: unsigned borrow from a (WIDTH+1)-bit difference, signed overflow
  // from the true signed difference falling outside the WIDTH-bit range.
  function automatic logic [RW-1:0] model(input logic [WIDTH-1:0] ma,
                                          input logic [WIDTH-1:0] mb,
                                          input logic mbin);
    logic [WIDTH:0]   ud;
    longint           sd;
    longint           lim;
    logic [WIDTH-1:0] dd;
    logic             o;
    ud  = {1'b0, ma} - {1'b0, mb} - {{WIDTH{1'b0}}, mbin};
    sd  = longint'($signed(ma)) - longint'($signed(mb)) - (mbin ? 64'sd1 : 64'sd0);
    lim = longint'(1) << (WIDTH - 1);
    o   = (sd >= lim) || (sd < -lim);
    dd  = ud[WIDTH-1:0];
    return {dd, ud[WIDTH], o, (dd == '0), dd[WIDTH-1]};
  endfunction

  // Issues one operation and returns in the done cycle (or after a bounded wait).
  // cyc counts cycles from the accept edge: done is expected in cycle NIB+1.
  task automatic run_op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                        input logic ibin, input bit hold,
                        output int cyc, output int busy_cnt, output bit overlap);
    a = ia;
    b = ib;
    bin = ibin;
    op_start = 1'b1;
    @(posedge clk); #1;
    if (!hold) op_start = 1'b0;
    cyc = 1;
    busy_cnt = 0;
    overlap = 1'b0;
    while (!done && cyc < 4 * NIB) begin
      if (busy) busy_cnt++;
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      bin = 1'($urandom_range(1, 0));
      @(posedge clk); #1;
      cyc++;
    end
    if (busy && done) overlap = 1'b1;
    op_start = 1'b0;
    $display("op a=%h b=%h bin=%0d -> d=%h bout=%0d ovf=%0d zero=%0d neg=%0d cyc=%0d",
             ia, ib, ibin, d, bout, ovf, zero, neg, cyc);
  endtask

  task automatic test_reset();
    #2;
    total_cnt++;
    if (observed() !== '0) $display("FAIL reset_result got=%h want=0", observed());
    else pass_cnt++;
    total_cnt++;
    if ({busy, done} !== 2'b00) $display("FAIL reset_busy_done got=%b want=00", {busy, done});
    else pass_cnt++;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [WIDTH-1:0] ta [6];
    logic [WIDTH-1:0] tb [6];
    logic             tbin [6];
    logic [RW-1:0]    texp [6];
    int cyc, bc;
    bit ov;
    ta[0] = 32'h5;        tb[0] = 32'h3;        tbin[0] = 0; texp[0] = {32'h00000002, 4'b0000};
    ta[1] = 32'h3;        tb[1] = 32'h5;        tbin[1] = 0; texp[1] = {32'hFFFFFFFE, 4'b1001};
    ta[2] = 32'h80000000; tb[2] = 32'h1;        tbin[2] = 0; texp[2] = {32'h7FFFFFFF, 4'b0100};
    ta[3] = 32'h7FFFFFFF; tb[3] = 32'hFFFFFFFF; tbin[3] = 0; texp[3] = {32'h80000000, 4'b1101};
    ta[4] = 32'h12345678; tb[4] = 32'h12345678; tbin[4] = 0; texp[4] = {32'h00000000, 4'b0010};
    ta[5] = 32'h12345678; tb[5] = 32'h12345678; tbin[5] = 1; texp[5] = {32'hFFFFFFFF, 4'b1001};
    for (int i = 0; i < 6; i++) begin
      run_op(ta[i], tb[i], tbin[i], 1'b0, cyc, bc, ov);
      total_cnt++;
      if (observed() !== texp[i]) $display("FAIL dir%0d_result got=%h want=%h", i, observed(), texp[i]);
      else pass_cnt++;
      total_cnt++;
      if (cyc !== NIB + 1) $display("FAIL dir%0d_latency got=%0d want=%0d", i, cyc, NIB + 1);
      else pass_cnt++;
      total_cnt++;
      if (bc !== NIB || ov) $display("FAIL dir%0d_busy got=%0d/%0d want=%0d/0", i, bc, ov, NIB);
      else pass_cnt++;
      // done is a single pulse and the result is held afterwards in IDLE
      @(posedge clk); #1;
      total_cnt++;
      if ({done, observed()} !== {1'b0, texp[i]})
        $display("FAIL dir%0d_hold got=%b/%h want=0/%h", i, done, observed(), texp[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] ra, rb;
    logic rbin;
    logic [RW-1:0] exp;
    int cyc, bc;
    bit ov;
    for (int i = 0; i < 30; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rbin = 1'($urandom_range(1, 0));
      case ($urandom_range(3, 0))
        0: rb = ra;
        1: begin ra = '0; ra[WIDTH-1] = 1'b1; end
        2: rb = ~ra;
        default: ;
      endcase
      exp = model(ra, rb, rbin);
      run_op(ra, rb, rbin, 1'b0, cyc, bc, ov);
      total_cnt++;
      if (observed() !== exp || cyc !== NIB + 1)
        $display("FAIL rnd%0d got=%h cyc=%0d want=%h cyc=%0d", i, observed(), cyc, exp, NIB + 1);
      else pass_cnt++;
    end
  endtask

  task automatic test_hold_start();
    logic [WIDTH-1:0] ra, rb;
    logic [RW-1:0] exp;
    int cyc, bc;
    bit ov;
    for (int i = 0; i < 3; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      exp = model(ra, rb, 1'b1);
      run_op(ra, rb, 1'b1, 1'b1, cyc, bc, ov);
      total_cnt++;
      if (observed() !== exp || cyc !== NIB + 1)
        $display("FAIL hold%0d got=%h cyc=%0d want=%h cyc=%0d", i, observed(), cyc, exp, NIB + 1);
      else pass_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] ra [3];
    logic [WIDTH-1:0] rb [3];
    logic [RW-1:0] exp;
    int cyc, bc;
    bit ov;
    for (int i = 0; i < 3; i++) begin
      ra[i] = WIDTH'($urandom);
      rb[i] = WIDTH'($urandom);
    end
    // Each run_op returns in the done cycle, so the next start overlaps it
    for (int i = 0; i < 3; i++) begin
      exp = model(ra[i], rb[i], 1'b0);
      run_op(ra[i], rb[i], 1'b0, 1'b0, cyc, bc, ov);
      total_cnt++;
      if (observed() !== exp || cyc !== NIB + 1 || bc !== NIB)
        $display("FAIL b2b%0d got=%h cyc=%0d busy=%0d want=%h cyc=%0d busy=%0d",
                 i, observed(), cyc, bc, exp, NIB + 1, NIB);
      else pass_cnt++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    int cyc, bc;
    bit ov;
    a = WIDTH'($urandom) | 32'h0F0F0F0F;
    b = WIDTH'($urandom);
    bin = 1'b0;
    op_start = 1'b1;
    @(posedge clk); #1;
    op_start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    // Now in the 4th RUN cycle; reset must clear outputs without a clock edge
    reset_n = 1'b0;
    #1;
    total_cnt++;
    if ({observed(), busy, done} !== '0)
      $display("FAIL mid_reset got=%h busy=%b done=%b want=0", observed(), busy, done);
    else pass_cnt++;
    @(posedge clk); #1;
    reset_n = 1'b1;
    run_op(32'd10, 32'd4, 1'b0, 1'b0, cyc, bc, ov);
    total_cnt++;
    if (observed() !== {32'd6, 4'b0000} || cyc !== NIB + 1)
      $display("FAIL post_reset got=%h cyc=%0d want=%h cyc=%0d", observed(), cyc, {32'd6, 4'b0000}, NIB + 1);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold_start();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
